arm_control_unit: RTL and testbench
===================================

// Module: arm_control_unit
// PURPOSE
//   Control unit driving the single-cycle ARM datapath: combinational main/ALU decoder on Instr fields plus
//   conditional-execution logic with an architectural NZCV flag register. Consumes Instr[31:12] and ALUFlags,
//   produces every datapath control strobe (PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl).
// PARAMETERS
//   PC_REG   4'd15  register index treated as PC; RegW to it converts the instruction into a branch (PCS)
// PORTS
//   CLK         in   1  single clock, rising edge
//   RST         in   1  synchronous reset, active-high
//   Cond        in   4  Instr[31:28] condition field
//   Op          in   2  Instr[27:26] 00 data-proc, 01 memory, 10 branch, 11 undefined
//   Funct       in   6  Instr[25:20]: [5]=I, [4:1]=cmd (DP) / [3]=U (mem), [0]=S (DP) / L (mem)
//   Rd          in   4  Instr[15:12] destination register
//   ALUFlags    in   4  live {N,Z,C,V} from the ALU for the current instruction
//   PCSrc       out  1  1 = next PC from Result
//   RegWrite    out  1  register-file WE3
//   MemWrite    out  1  data-memory write enable
//   MemtoReg    out  1  1 = write back ReadData, 0 = ALUResult
//   ALUSrc      out  2  00 = RD2, 01 = extended immediate, 1x never driven
//   ImmSrc      out  2  00 = imm8 (DP), 01 = imm12 (mem), 10 = imm24<<2 (branch)
//   RegSrc      out  2  [0]=1 RA1 = PC (branch); [1]=1 RA2 = Rd (STR)
//   ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//   Flags       out  4  registered {N,Z,C,V} (debug/observability)
// BEHAVIOUR
//   - Decode purely combinational, zero latency; the only state is Flags[3:0].
//   - Op=00, Funct[5]=0: RegW=1, ALUSrc=00, ImmSrc=00, RegSrc=00. Funct[5]=1: same but ALUSrc=01.
//   - DP cmd Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd: RegW=0, FlagW=00 (NOP).
//   - Op=01, L=1 (LDR): RegW=1, MemtoReg=1, ALUSrc=01, ImmSrc=01, RegSrc=00. L=0 (STR): MemW=1,
//     ALUSrc=01, ImmSrc=01, RegSrc=10. ALUControl = U ? ADD : SUB.
//   - Op=10 (B): Branch=1, ALUSrc=01, ImmSrc=10, RegSrc=01, ALUControl=ADD, RegW=0.
//   - Op=11: all write strobes 0, other outputs 0.
//   - FlagW[1] (NZ) = S & DP & valid cmd; FlagW[0] (CV) = S & DP & cmd in {ADD,SUB}. Mem/branch never set flags.
//   - PCS = Branch | (RegW & Rd==PC_REG).
//   - CondEx from registered Flags per ARM table: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 4'b1111 -> CondEx=0.
//   - PCSrc = PCS&CondEx; RegWrite = RegW&CondEx&~NoWrite; MemWrite = MemW&CondEx; other outputs ungated.
//   - Flag register, rising CLK: if RST -> 4'b0000; else Flags[3:2] <= ALUFlags[3:2] when FlagW[1]&CondEx;
//     Flags[1:0] <= ALUFlags[1:0] when FlagW[0]&CondEx; otherwise hold.
//   - An S-instruction evaluates its own Cond against the OLD flags; new flags visible from the next cycle.
//   - While RST=1: PCSrc, RegWrite, MemWrite forced 0 combinationally (no architectural side effects mid-reset);
//     Flags read as 0000 the cycle after RST sampled high. Reset asserted mid-program discards no more than
//     the instruction present in that cycle.
// CONFIGURATION
//   ARM_CTRL_CMP_EN defined: cmd 1010 decodes as CMP -> ALUControl=SUB, NoWrite=1, FlagW=11
//     (flags updated, RegWrite=0, PCS=0 even if Rd=PC_REG).
//   Undefined: cmd 1010 falls into the NOP case (RegW=0, FlagW=00). NoWrite tied 0.
// STRUCTURE
//   - Package arm_ctrl_pkg: ALU op encodings (ADD/SUB/AND/ORR), Op encodings, DP cmd codes,
//     condition codes (EQ..AL), ImmSrc/ALUSrc/RegSrc encodings, flag bit indices.
//   - Sub-module arm_cond_logic: flag register + CondEx + output gating; top holds decoders.
// TESTING
//   - RST=1 two cycles, Op=00 ADD Cond=AL -> RegWrite=0 during reset, Flags=0000 afterwards, then RegWrite=1.
//   - SUBS (cmd 0010,S=1,Cond=AL) with ALUFlags=0100 -> next cycle Flags=0100; following BEQ (Op=10,Cond=0000)
//     -> PCSrc=1, ImmSrc=10, RegSrc=01; same BNE (0001) -> PCSrc=0.
//   - ANDS with ALUFlags=1011, prior Flags=0000 -> Flags=1000 (C,V held); ADDS same ALUFlags -> Flags=1011.
//   - STR U=0 Cond=AL -> MemWrite=1, RegWrite=0, RegSrc=10, ALUControl=01; Cond=1111 -> MemWrite=0.
//   - ADD Rd=15 Cond=AL -> PCSrc=1, RegWrite=1; Op=11 -> all strobes 0, Flags held.
//   - ARM_CTRL_CMP_EN: CMP ALUFlags=0110 -> RegWrite=0, Flags=0110 next cycle; without macro -> Flags unchanged.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the single-cycle ARM control unit: ALU ops, opcodes,
// data-processing commands, condition codes, mux selects and flag bit indices.
package arm_ctrl_pkg;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] ALUSRC_RD2 = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  localparam logic [1:0] REGSRC_STD = 2'b00;
  localparam logic [1:0] REGSRC_PC  = 2'b01;
  localparam logic [1:0] REGSRC_RD  = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_control_unit_if.sv
// Instruction-field / control-strobe bundle between datapath (master) and
// control unit (slave).
interface arm_control_unit_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemtoReg;
  logic [1:0] ALUSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] Flags;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, Flags
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, Flags
  );
endinterface

// File: rtl/arm_cond_logic.sv
// NZCV flag register, condition evaluation against the registered flags, and
// gating of the architectural write strobes (forced off while RST is high).
module arm_cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign n = flags_q[FLAG_N];
  assign z = flags_q[FLAG_Z];
  assign c = flags_q[FLAG_C];
  assign v = flags_q[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // NZ and CV update independently so logical ops leave C/V untouched.
  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  assign pc_src    = ~rst & pcs & cond_ex;
  assign reg_write = ~rst & reg_w & cond_ex & ~no_write;
  assign mem_write = ~rst & mem_w & cond_ex;
  assign flags     = flags_q;

endmodule

// File: rtl/arm_control_unit.sv
// Single-cycle ARM control unit: main/ALU decode here, conditional execution
// in arm_cond_logic. Define ARM_CTRL_CMP_EN to decode cmd 1010 as CMP.
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  arm_control_unit_if.slave   bus
);

  logic       reg_w, mem_w, mem_to_reg, branch, no_write, pcs, s_bit;
  logic [1:0] alu_src, imm_src, reg_src, alu_ctrl, flag_w;

  assign s_bit = bus.Funct[0];

  always_comb begin
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    no_write   = 1'b0;
    alu_src    = ALUSRC_RD2;
    imm_src    = IMM_DP;
    reg_src    = REGSRC_STD;
    alu_ctrl   = ALU_ADD;
    flag_w     = 2'b00;
    case (bus.Op)
      OP_DP: begin
        alu_src = bus.Funct[5] ? ALUSRC_IMM : ALUSRC_RD2;
        case (bus.Funct[4:1])
          CMD_ADD: begin reg_w = 1'b1; alu_ctrl = ALU_ADD; flag_w = {2{s_bit}};  end
          CMD_SUB: begin reg_w = 1'b1; alu_ctrl = ALU_SUB; flag_w = {2{s_bit}};  end
          CMD_AND: begin reg_w = 1'b1; alu_ctrl = ALU_AND; flag_w = {s_bit, 1'b0}; end
          CMD_ORR: begin reg_w = 1'b1; alu_ctrl = ALU_ORR; flag_w = {s_bit, 1'b0}; end
`ifdef ARM_CTRL_CMP_EN
          CMD_CMP: begin reg_w = 1'b1; no_write = 1'b1; alu_ctrl = ALU_SUB; flag_w = 2'b11; end
`endif
          default: ;
        endcase
      end
      OP_MEM: begin
        alu_src  = ALUSRC_IMM;
        imm_src  = IMM_MEM;
        alu_ctrl = bus.Funct[3] ? ALU_ADD : ALU_SUB;
        if (bus.Funct[0]) begin
          reg_w      = 1'b1;
          mem_to_reg = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = REGSRC_RD;
        end
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = ALUSRC_IMM;
        imm_src = IMM_BR;
        reg_src = REGSRC_PC;
      end
      default: ;
    endcase
  end

  // A compare never redirects the PC even when its Rd field names the PC.
  assign pcs = branch | (reg_w & ~no_write & (bus.Rd == PC_REG));

  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrc     = alu_src;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegSrc     = reg_src;
  assign bus.ALUControl = alu_ctrl;

  arm_cond_logic u_cond (
    .clk       (CLK),
    .rst       (RST),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (bus.PCSrc),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite),
    .flags     (bus.Flags)
  );

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed-vector bench for arm_control_unit; expectations hand-derived from
// the ARM decode/condition tables.
module tb_arm_control_unit;

  logic CLK, RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  arm_control_unit_if bus ();

  arm_control_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Present a new instruction just after the rising edge, then wait for the
  // falling edge where combinational outputs and the flag register are checked.
  task automatic issue(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af);
    @(posedge CLK);
    #1;
    bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd1; bus.ALUFlags = 4'b0000;
    @(negedge CLK);
    chk("rst_regwrite0", {7'b0, bus.RegWrite}, 8'd0);
    chk("rst_pcsrc0",    {7'b0, bus.PCSrc},    8'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_regwrite1", {7'b0, bus.RegWrite}, 8'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_flags",   {4'b0, bus.Flags},      8'h00);
    chk("add_regwr",   {7'b0, bus.RegWrite},   8'd1);
    chk("add_aluctl",  {6'b0, bus.ALUControl}, 8'd0);
    chk("add_alusrc",  {6'b0, bus.ALUSrc},     8'd0);

    // SUBS, ALUFlags Z set
    issue(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100);
    chk("subs_aluctl", {6'b0, bus.ALUControl}, 8'd1);
    chk("subs_regwr",  {7'b0, bus.RegWrite},   8'd1);
    chk("subs_oldflg", {4'b0, bus.Flags},      8'h00);
    // BEQ taken
    issue(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("beq_flags",   {4'b0, bus.Flags},      8'h04);
    chk("beq_pcsrc",   {7'b0, bus.PCSrc},      8'd1);
    chk("beq_immsrc",  {6'b0, bus.ImmSrc},     8'd2);
    chk("beq_regsrc",  {6'b0, bus.RegSrc},     8'd1);
    chk("beq_alusrc",  {6'b0, bus.ALUSrc},     8'd1);
    chk("beq_regwr",   {7'b0, bus.RegWrite},   8'd0);
    // BNE not taken
    issue(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("bne_pcsrc",   {7'b0, bus.PCSrc},      8'd0);

    // Mid-program reset: branch AL present during reset must not redirect
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.Cond = 4'b1110; bus.Op = 2'b10; bus.Funct = 6'b000000; bus.Rd = 4'd0; bus.ALUFlags = 4'b0000;
    @(negedge CLK);
    chk("midrst_pcsrc", {7'b0, bus.PCSrc}, 8'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // ANDS with prior flags 0000: only N,Z taken
    bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b000001; bus.Rd = 4'd3; bus.ALUFlags = 4'b1011;
    @(negedge CLK);
    chk("midrst_flags", {4'b0, bus.Flags},      8'h00);
    chk("ands_aluctl",  {6'b0, bus.ALUControl}, 8'd2);
    issue(4'b1110, 2'b00, 6'b001001, 4'd3, 4'b1011);  // ADDS
    chk("ands_flags",   {4'b0, bus.Flags},      8'h08);
    // ORR immediate, no S
    issue(4'b1110, 2'b00, 6'b111000, 4'd4, 4'b0000);
    chk("adds_flags",   {4'b0, bus.Flags},      8'h0b);
    chk("orr_aluctl",   {6'b0, bus.ALUControl}, 8'd3);
    chk("orr_alusrc",   {6'b0, bus.ALUSrc},     8'd1);

    // STR U=0
    issue(4'b1110, 2'b01, 6'b000000, 4'd5, 4'b0000);
    chk("str_memwr",   {7'b0, bus.MemWrite},   8'd1);
    chk("str_regwr",   {7'b0, bus.RegWrite},   8'd0);
    chk("str_regsrc",  {6'b0, bus.RegSrc},     8'd2);
    chk("str_aluctl",  {6'b0, bus.ALUControl}, 8'd1);
    chk("str_immsrc",  {6'b0, bus.ImmSrc},     8'd1);
    issue(4'b1111, 2'b01, 6'b000000, 4'd5, 4'b0000);
    chk("str_nv_memwr", {7'b0, bus.MemWrite},  8'd0);
    // LDR U=1
    issue(4'b1110, 2'b01, 6'b001001, 4'd6, 4'b0000);
    chk("ldr_regwr",   {7'b0, bus.RegWrite},   8'd1);
    chk("ldr_memtorg", {7'b0, bus.MemtoReg},   8'd1);
    chk("ldr_aluctl",  {6'b0, bus.ALUControl}, 8'd0);
    chk("ldr_memwr",   {7'b0, bus.MemWrite},   8'd0);

    // Conditions against Flags=1011 (N=1 Z=0 C=1 V=1)
    issue(4'b1010, 2'b00, 6'b001000, 4'd1, 4'b0000);
    chk("ge_regwr", {7'b0, bus.RegWrite}, 8'd1);
    issue(4'b1011, 2'b00, 6'b001000, 4'd1, 4'b0000);
    chk("lt_regwr", {7'b0, bus.RegWrite}, 8'd0);
    issue(4'b1000, 2'b00, 6'b001000, 4'd1, 4'b0000);
    chk("hi_regwr", {7'b0, bus.RegWrite}, 8'd1);
    issue(4'b1101, 2'b00, 6'b001000, 4'd1, 4'b0000);
    chk("le_regwr", {7'b0, bus.RegWrite}, 8'd0);

    // ADD Rd=PC
    issue(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
    chk("addpc_pcsrc", {7'b0, bus.PCSrc},    8'd1);
    chk("addpc_regwr", {7'b0, bus.RegWrite}, 8'd1);
    // Op=11 with S-like funct bits
    issue(4'b1110, 2'b11, 6'b001001, 4'd15, 4'b0000);
    chk("und_strobes", {5'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, 8'd0);
    chk("und_others",  {bus.ALUSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl}, 8'd0);
    // ADDS with failing EQ: flags held
    issue(4'b0000, 2'b00, 6'b001001, 4'd1, 4'b0100);
    chk("und_flags",   {4'b0, bus.Flags},    8'h0b);
    chk("addseq_regwr", {7'b0, bus.RegWrite}, 8'd0);
    // Unsupported cmd 0001 with S: NOP
    issue(4'b1110, 2'b00, 6'b000011, 4'd1, 4'b0000);
    chk("eqfail_flags", {4'b0, bus.Flags},   8'h0b);
    chk("nop_regwr",   {7'b0, bus.RegWrite}, 8'd0);
    // CMP Rd=PC
    issue(4'b1110, 2'b00, 6'b010101, 4'd15, 4'b0110);
    chk("nop_flags",   {4'b0, bus.Flags},    8'h0b);
    chk("cmp_regwr",   {7'b0, bus.RegWrite}, 8'd0);
    chk("cmp_pcsrc",   {7'b0, bus.PCSrc},    8'd0);
    issue(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
`ifdef ARM_CTRL_CMP_EN
    chk("cmp_flags",   {4'b0, bus.Flags},    8'h06);
`else
    chk("cmp_flags",   {4'b0, bus.Flags},    8'h0b);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
